debounce_fsm: RTL

//   Cleans a raw asynchronous pushbutton/switch input before it reaches the edge-detector FSM.

---
 rtl/debounce_pkg.sv | 8 +
 rtl/debounce_fsm_sync_chain.sv | 25 ++
 rtl/debounce_fsm.sv | 125 ++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the pushbutton debouncer.
package debounce_pkg;

   typedef enum logic [1:0] {ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW} db_state_t;

   localparam int GLITCH_W = 8;

endpackage

// File: rtl/debounce_fsm_sync_chain.sv
// sync_chain: reset-to-0 flop chain that brings an asynchronous pin into the
// clk domain. q is the last stage; STAGES must be at least 2.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_p0;

   // Shift the pin through the chain; only the oldest stage is used downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
      end else begin
         sync_p0 <= {sync_p0[STAGES-2:0], d};
      end
   end

   assign q = sync_p0[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronises a bouncing pin and only changes db_level after
// DEBOUNCE_CYCLES consecutive stable synchronised samples.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to count aborted transitions
// on glitch_cnt (saturating); otherwise glitch_cnt is constant zero.
module debounce_fsm
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                raw_in,
   output logic                db_level,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             in_sync;
   db_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (raw_in),
      .q     (in_sync)
   );

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic                abort;
   logic [GLITCH_W-1:0] glitch_q;

   function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
      return (v == '1) ? v : v + GLITCH_W'(1);
   endfunction

   // A reversal seen while qualifying sends the FSM back to its stable state.
   assign abort = ((state == ST_WAIT_HIGH) && !in_sync) ||
                  ((state == ST_WAIT_LOW)  &&  in_sync);
   assign glitch_cnt = glitch_q;
`else
   assign glitch_cnt = '0;
`endif

   // Next state and qualification counter; counter restarts on every WAIT entry.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_LOW: begin
            if (in_sync) begin
               state_nxt = ST_WAIT_HIGH;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_HIGH: begin
            if (!in_sync) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (!in_sync) begin
               state_nxt = ST_WAIT_LOW;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_LOW: begin
            if (in_sync) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and glitch count; reset discards any qualification in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_LOW;
         cnt      <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         glitch_q <= '0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         if (abort) begin
            glitch_q <= sat_inc(glitch_q);
         end
`endif
      end
   end

   // Registered Moore outputs decoded from the next state so they track state exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_level <= 1'b0;
         busy     <= 1'b0;
      end else begin
         db_level <= (state_nxt == ST_HIGH) || (state_nxt == ST_WAIT_LOW);
         busy     <= (state_nxt == ST_WAIT_HIGH) || (state_nxt == ST_WAIT_LOW);
      end
   end

endmodule
